linea_tx: RTL

//  Serial transmitter for the 7-state linea/u recognizer. It serialises

---
 rtl/linea_tx.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/linea_tx.sv
// Serial transmitter feeding the 7-state linea/u recognizer.
// Each bit occupies one 4-cycle slot on 'linea'. A '1' data bit or a start
// bit is sent as the detect pattern selected by PATH, so the recognizer
// pulses u. A '0' data bit and every idle slot are sent as the filler
// 1,1,1,0, which returns the recognizer to its sampling state silently.
// The slot phase free-runs from reset so it stays locked to the recognizer.
module linea_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit START_BIT = 1'b1,
    parameter int PATH      = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             linea,
    output logic             busy,
    output logic             tx_done
);

    // Slots per word and the counter width able to hold that value.
    localparam int TOTAL = WIDTH + int'(START_BIT);
    localparam int CNT_W = $clog2(TOTAL + 1);

    // Line values for ph0..ph3, bit index == phase. The detect pattern
    // always drives 0 in ph3 because the recognizer ignores that sample.
    localparam logic [3:0] FILLER_PAT = 4'b0111;
    localparam logic [3:0] DETECT_PAT = (PATH == 1) ? 4'b0001 :
                                        (PATH == 2) ? 4'b0010 : 4'b0000;

    // Illegal parameter values stop elaboration instead of producing a
    // transmitter the recognizer can never decode.
    if (PATH < 0 || PATH > 2) begin : g_bad_path
        $error("linea_tx: PATH must be 0, 1 or 2");
    end
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("linea_tx: WIDTH must be within 1..32");
    end

    // What the current slot carries; latched on the ph0 edge.
    typedef enum logic [1:0] {
        KIND_FILLER,
        KIND_ZERO,
        KIND_ONE
    } kind_e;

    logic [1:0]       ph_q, ph_d;
    logic [CNT_W-1:0] bits_left_q, bits_left_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             start_pend_q, start_pend_d;
    kind_e            kind_q, kind_d;
    logic             bit_slot_q, bit_slot_d;   // slot carries a word bit
    logic             last_slot_q, last_slot_d; // ...and it is the word's last
    logic             linea_q, linea_d;
    logic             tx_done_q, tx_done_d;

    logic             load;
    logic             next_bit;
    logic [3:0]       slot_pat;

    assign in_ready = (bits_left_q == '0);
    assign load     = in_valid && in_ready;
    assign next_bit = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];

    // Next-state logic: slot selection on ph0, word load, line pattern.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path through
        // this block can leave one unassigned and infer a latch.
        ph_d         = ph_q + 2'd1;
        bits_left_d  = bits_left_q;
        shift_d      = shift_q;
        start_pend_d = start_pend_q;
        kind_d       = kind_q;
        bit_slot_d   = bit_slot_q;
        last_slot_d  = last_slot_q;
        tx_done_d    = 1'b0;

        if (ph_q == 2'd0) begin
            if (bits_left_q != '0) begin
                bit_slot_d  = 1'b1;
                last_slot_d = (bits_left_q == CNT_W'(1));
                bits_left_d = bits_left_q - CNT_W'(1);
                if (start_pend_q) begin
                    kind_d       = KIND_ONE;
                    start_pend_d = 1'b0;
                end else begin
                    kind_d  = next_bit ? KIND_ONE : KIND_ZERO;
                    shift_d = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
                end
            end else begin
                kind_d      = KIND_FILLER;
                bit_slot_d  = 1'b0;
                last_slot_d = 1'b0;
            end
        end else if (ph_q == 2'd3) begin
            // The slot's final line value goes out on this edge.
            tx_done_d  = bit_slot_q && last_slot_q;
            bit_slot_d = 1'b0;
        end

        // A load only happens with nothing held, so it never races the
        // ph0 consumption above; on a ph0 edge that slot stays filler.
        if (load) begin
            shift_d      = in_data;
            bits_left_d  = CNT_W'(TOTAL);
            start_pend_d = START_BIT;
        end

        slot_pat = (kind_d == KIND_ONE) ? DETECT_PAT : FILLER_PAT;
        linea_d  = slot_pat[ph_q];
    end

    // State register; reset drops any word in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ph_q         <= 2'd0;
            bits_left_q  <= '0;
            shift_q      <= '0;
            start_pend_q <= 1'b0;
            kind_q       <= KIND_FILLER;
            bit_slot_q   <= 1'b0;
            last_slot_q  <= 1'b0;
            linea_q      <= 1'b0;
            tx_done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            ph_q         <= ph_d;
            bits_left_q  <= bits_left_d;
            shift_q      <= shift_d;
            start_pend_q <= start_pend_d;
            kind_q       <= kind_d;
            bit_slot_q   <= bit_slot_d;
            last_slot_q  <= last_slot_d;
            linea_q      <= linea_d;
            tx_done_q    <= tx_done_d;
        end
    end

    assign linea   = linea_q;
    assign tx_done = tx_done_q;
    assign busy    = (bits_left_q != '0) || bit_slot_q;

endmodule
